// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmit engine between two byte sources.
//
// Source A (echo path) and source B (local message/status generator) each feed
// a small FIFO. An FSM round-robins between the non-empty FIFOs. It drives the
// transmitter with a level start that is held until the transmitter reports
// busy (tx_ready_i low) and then done (tx_ready_i high again). A watchdog
// abandons the byte if either wait lasts TIMEOUT cycles.
//
// Ports
//   clk_i          system clock, all logic on posedge
//   rst_i          synchronous active-low reset
//   a_data_i/a_valid_i/a_ready_o   source A byte stream
//   b_data_i/b_valid_i/b_ready_o   source B byte stream
//   tx_word_o      byte presented to the transmitter (held until next grant)
//   tx_start_o     level request to the transmitter
//   tx_ready_i     transmitter idle/finished
//   grant_o        source of current/last byte: 0=A, 1=B
//   busy_o         FSM not in IDLE
//   timeout_err_o  one-cycle pulse on watchdog abort
//
// Parameters
//   FIFO_DEPTH     entries per source FIFO, power of 2, >= 2
//   TIMEOUT        cycles allowed in each wait state, 2..1023

// Per-source byte FIFO. No bypass: a pushed byte becomes visible at the head
// one edge later. The occupancy count is one bit wider than the pointers so
// full and empty can be told apart.
module uart_tx_arbiter_fifo #(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic       full_o,
  output logic       empty_o,
  output logic [7:0] head_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0]   CNT_ONE  = (AW + 1)'(1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop_i)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an empty FIFO never exposes its contents.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign full_o  = (count_q == FULL_CNT);
  assign empty_o = (count_q == '0);
  assign head_o  = mem_q[rd_ptr_q];

endmodule

// state      | meaning
// S_IDLE     | no byte in flight; picks a source when tx_ready_i=1
// S_WAIT_BUSY| start raised, waiting for the transmitter to drop tx_ready_i
// S_WAIT_DONE| transmitter busy, waiting for tx_ready_i to return high
module uart_tx_arbiter #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 1023
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] a_data_i,
  input  logic       a_valid_i,
  output logic       a_ready_o,
  input  logic [7:0] b_data_i,
  input  logic       b_valid_i,
  output logic       b_ready_o,
  output logic [7:0] tx_word_o,
  output logic       tx_start_o,
  input  logic       tx_ready_i,
  output logic       grant_o,
  output logic       busy_o,
  output logic       timeout_err_o
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_BUSY = 2'd1,
    S_WAIT_DONE = 2'd2
  } state_t;

  localparam logic [9:0] CNT_LAST = 10'(TIMEOUT - 1);

  state_t     state_q, state_d;
  logic [9:0] cnt_q, cnt_d;
  logic       rr_pri_q, rr_pri_d;
  logic       grant_q, grant_d;
  logic [7:0] tx_word_q, tx_word_d;
  logic       tx_start_q, tx_start_d;
  logic       timeout_err_q, timeout_err_d;
  logic       rdy_en_q;

  logic       full_a, empty_a, full_b, empty_b;
  logic [7:0] head_a, head_b;
  logic       push_a, push_b, pop_a, pop_b;
  logic       sel_b;

  // Ready is gated by a flag that only sets on the first edge out of reset,
  // so neither source sees ready while reset is held.
  assign a_ready_o = rdy_en_q && !full_a;
  assign b_ready_o = rdy_en_q && !full_b;
  assign push_a    = a_valid_i && a_ready_o;
  assign push_b    = b_valid_i && b_ready_o;

  uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_a (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_a),
    .data_i  (a_data_i),
    .pop_i   (pop_a),
    .full_o  (full_a),
    .empty_o (empty_a),
    .head_o  (head_a)
  );

  uart_tx_arbiter_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_b (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_b),
    .data_i  (b_data_i),
    .pop_i   (pop_b),
    .full_o  (full_b),
    .empty_o (empty_b),
    .head_o  (head_b)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rr_pri_d      = rr_pri_q;
    grant_d       = grant_q;
    tx_word_d     = tx_word_q;
    tx_start_d    = tx_start_q;
    timeout_err_d = 1'b0;
    pop_a         = 1'b0;
    pop_b         = 1'b0;
    sel_b         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (tx_ready_i && (!empty_a || !empty_b)) begin
          // A lone non-empty FIFO wins outright; otherwise rr_pri decides.
          if (empty_a)      sel_b = 1'b1;
          else if (empty_b) sel_b = 1'b0;
          else              sel_b = rr_pri_q;
          pop_a      = !sel_b;
          pop_b      = sel_b;
          tx_word_d  = sel_b ? head_b : head_a;
          grant_d    = sel_b;
          tx_start_d = 1'b1;
          cnt_d      = '0;
          state_d    = S_WAIT_BUSY;
        end
      end

      S_WAIT_BUSY: begin
        if (!tx_ready_i) begin
          cnt_d   = '0;
          state_d = S_WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          tx_start_d    = 1'b0;
          timeout_err_d = 1'b1;
          rr_pri_d      = !grant_q;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      S_WAIT_DONE: begin
        // Completion is tested first so a handshake landing on the last
        // allowed cycle is not reported as a timeout.
        if (tx_ready_i) begin
          tx_start_d = 1'b0;
          rr_pri_d   = !grant_q;
          state_d    = S_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          tx_start_d    = 1'b0;
          timeout_err_d = 1'b1;
          rr_pri_d      = !grant_q;
          state_d       = S_IDLE;
        end else begin
          cnt_d = cnt_q + 10'd1;
        end
      end

      default: begin
        tx_start_d = 1'b0;
        state_d    = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      rr_pri_q      <= 1'b0;
      grant_q       <= 1'b0;
      tx_word_q     <= '0;
      tx_start_q    <= 1'b0;
      timeout_err_q <= 1'b0;
      rdy_en_q      <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rr_pri_q      <= rr_pri_d;
      grant_q       <= grant_d;
      tx_word_q     <= tx_word_d;
      tx_start_q    <= tx_start_d;
      timeout_err_q <= timeout_err_d;
      rdy_en_q      <= 1'b1;
    end
  end

  assign tx_word_o     = tx_word_q;
  assign tx_start_o    = tx_start_q;
  assign grant_o       = grant_q;
  assign busy_o        = (state_q != S_IDLE);
  assign timeout_err_o = timeout_err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter. Directed stimulus pushes expected transfers
// {word, grant, start length, timeout flag} into a queue; a monitor checks each
// tx_start pulse against the head of that queue. A transmitter model answers
// tx_start with a programmable ready-drop delay and busy length.
module tb_uart_tx_arbiter;

  localparam int DEPTH = 4;
  localparam int TMO   = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] a_data, b_data;
  logic       a_valid, b_valid;
  logic       a_ready, b_ready;
  logic [7:0] tx_word;
  logic       tx_start;
  logic       tx_ready;
  logic       grant, busy, timeout_err;

  logic man_rdy;
  logic mdl_en;
  logic mdl_rdy;
  assign tx_ready = mdl_en ? mdl_rdy : man_rdy;

  always #5 clk = ~clk;

  uart_tx_arbiter #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk_i         (clk),
    .rst_i         (rst_n),
    .a_data_i      (a_data),
    .a_valid_i     (a_valid),
    .a_ready_o     (a_ready),
    .b_data_i      (b_data),
    .b_valid_i     (b_valid),
    .b_ready_o     (b_ready),
    .tx_word_o     (tx_word),
    .tx_start_o    (tx_start),
    .tx_ready_i    (tx_ready),
    .grant_o       (grant),
    .busy_o        (busy),
    .timeout_err_o (timeout_err)
  );

  typedef struct {
    logic [7:0] word;
    logic       grant;
    int         len;   // 0: length not checked
    logic       err;
  } exp_t;

  typedef struct {
    int drop;  // cycles from start until ready seen low; 0 = never drops
    int hold;  // cycles ready stays low; 0 = never returns on its own
  } mdl_t;

  exp_t exp_q[$];
  mdl_t mdl_q[$];
  int   total  = 0;
  int   passed = 0;
  int   a_cnt  = 0;
  int   b_cnt  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("FAIL %s: got %0h, required %0h", name, act, req);
  endtask

  task automatic exp_push(input logic [7:0] w, input logic g, input int len, input logic err);
    exp_t e;
    e.word = w; e.grant = g; e.len = len; e.err = err;
    exp_q.push_back(e);
  endtask

  task automatic mdl_push(input int drop, input int hold);
    mdl_t m;
    m.drop = drop; m.hold = hold;
    mdl_q.push_back(m);
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic push_a(input logic [7:0] d);
    int g = 0;
    a_data  = d;
    a_valid = 1'b1;
    while (!a_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!a_ready) begin
      total++;
      $display("FAIL push_a_wait: a_ready=%0b, required 1", a_ready);
      a_valid = 1'b0;
      return;
    end
    @(negedge clk);
    a_cnt++;
    a_valid = 1'b0;
  endtask

  task automatic push_b(input logic [7:0] d);
    int g = 0;
    b_data  = d;
    b_valid = 1'b1;
    while (!b_ready && g < 300) begin
      @(negedge clk);
      g++;
    end
    if (!b_ready) begin
      total++;
      $display("FAIL push_b_wait: b_ready=%0b, required 1", b_ready);
      b_valid = 1'b0;
      return;
    end
    @(negedge clk);
    b_cnt++;
    b_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n   = 1'b0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    mdl_en  = 1'b0;
    man_rdy = 1'b0;
    mdl_q.delete();
    a_cnt = 0;
    b_cnt = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_drain(input int lim);
    int n = 0;
    while ((exp_q.size() != 0 || busy || tx_start) && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (n >= lim) begin
      total++;
      $display("FAIL drain_timeout: %0d transfers still pending after %0d cycles, required 0", exp_q.size(), lim);
    end
    repeat (2) @(negedge clk);
  endtask

  // Transmitter model.
  initial begin : model
    mdl_t p;
    int   n;
    mdl_rdy = 1'b1;
    forever begin
      @(negedge clk);
      if (mdl_en && tx_start) begin
        if (mdl_q.size() > 0) p = mdl_q.pop_front();
        else begin p.drop = 3; p.hold = 10; end
        if (p.drop > 0) begin
          repeat (p.drop - 1) @(negedge clk);
          mdl_rdy = 1'b0;
          if (p.hold > 0) begin
            repeat (p.hold) @(negedge clk);
            mdl_rdy = 1'b1;
          end
        end
        n = 0;
        while (tx_start && n < 200) begin
          @(negedge clk);
          n++;
        end
        mdl_rdy = 1'b1;
      end
    end
  end

  // Scoreboard monitor.
  initial begin : monitor
    logic prev;
    logic have;
    int   len;
    exp_t cur;
    prev = 1'b0;
    have = 1'b0;
    len  = 0;
    forever begin
      @(negedge clk);
      if (tx_start === 1'b1 && !prev) begin
        len = 1;
        if (exp_q.size() == 0) begin
          total++;
          have = 1'b0;
          $display("FAIL unexpected_start: word %0h grant %0b, required no transfer", tx_word, grant);
        end else begin
          cur  = exp_q.pop_front();
          have = 1'b1;
          chk("tx_word", 32'(tx_word), 32'(cur.word));
          chk("grant", 32'(grant), 32'(cur.grant));
          chk("busy_at_start", 32'(busy), 32'(1'b1));
        end
      end else if (tx_start === 1'b1) begin
        len++;
        if (have && tx_word !== cur.word) chk("tx_word_held", 32'(tx_word), 32'(cur.word));
      end else if (prev) begin
        if (have) begin
          if (cur.len != 0) chk("start_len", 32'(len), 32'(cur.len));
          chk("timeout_err", 32'(timeout_err), 32'(cur.err));
        end
        have = 1'b0;
      end
      if (timeout_err === 1'b1 && !(prev && tx_start === 1'b0))
        chk("stray_timeout_err", 32'(timeout_err), 32'(1'b0));
      prev = (tx_start === 1'b1);
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL global_timeout: bench did not finish, required completion");
    $fatal(1, "global timeout");
  end

  initial begin : stim
    int n;
    rst_n   = 1'b0;
    a_data  = '0;
    b_data  = '0;
    a_valid = 1'b0;
    b_valid = 1'b0;
    man_rdy = 1'b0;
    mdl_en  = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_tx_word", 32'(tx_word), 32'(8'h00));
    chk("rst_tx_start", 32'(tx_start), 32'(1'b0));
    chk("rst_grant", 32'(grant), 32'(1'b0));
    chk("rst_busy", 32'(busy), 32'(1'b0));
    chk("rst_timeout_err", 32'(timeout_err), 32'(1'b0));
    chk("rst_a_ready", 32'(a_ready), 32'(1'b0));
    chk("rst_b_ready", 32'(b_ready), 32'(1'b0));
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_a_ready", 32'(a_ready), 32'(1'b1));
    chk("post_rst_b_ready", 32'(b_ready), 32'(1'b1));

    // Single byte, one-cycle latency from push to start
    mdl_en = 1'b1;
    exp_push(8'h41, 1'b0, 13, 1'b0);
    push_a(8'h41);
    chk("latency_before", 32'(tx_start), 32'(1'b0));
    @(negedge clk);
    chk("latency_start", 32'(tx_start), 32'(1'b1));
    wait_drain(100);
    chk("idle_word_held", 32'(tx_word), 32'(8'h41));
    chk("idle_grant_held", 32'(grant), 32'(1'b0));

    // Round robin with both FIFOs preloaded
    do_reset();
    exp_push(8'h10, 1'b0, 13, 1'b0);
    exp_push(8'h20, 1'b1, 13, 1'b0);
    exp_push(8'h11, 1'b0, 13, 1'b0);
    exp_push(8'h21, 1'b1, 13, 1'b0);
    fork
      begin push_a(8'h10); push_a(8'h11); end
      begin push_b(8'h20); push_b(8'h21); end
    join
    chk("rr_idle_while_not_ready", 32'(busy), 32'(1'b0));
    mdl_en = 1'b1;
    wait_drain(200);

    // Full FIFO backpressure, 6 bytes through a 4-deep FIFO
    do_reset();
    for (int i = 0; i < 6; i++) exp_push(8'h50 + 8'(i), 1'b0, 13, 1'b0);
    fork
      begin
        for (int i = 0; i < 6; i++) push_a(8'h50 + 8'(i));
      end
      begin
        n = 0;
        while (a_cnt < 4 && n < 50) begin
          @(negedge clk);
          n++;
        end
        chk("bp_accepted_4", 32'(a_cnt), 32'(4));
        chk("bp_a_ready_full", 32'(a_ready), 32'(1'b0));
        chk("bp_b_ready_free", 32'(b_ready), 32'(1'b1));
        repeat (5) @(negedge clk);
        chk("bp_still_held", 32'(a_cnt), 32'(4));
        chk("bp_a_ready_still", 32'(a_ready), 32'(1'b0));
        mdl_en = 1'b1;
      end
    join
    wait_drain(300);
    chk("bp_all_accepted", 32'(a_cnt), 32'(6));

    // Watchdog: busy-wait timeout, handshake on last cycle, done-wait timeout
    do_reset();
    mdl_push(0, 0);
    mdl_push(3, TMO);
    mdl_push(3, 0);
    mdl_push(3, 10);
    exp_push(8'h60, 1'b0, TMO, 1'b1);
    exp_push(8'h70, 1'b1, 3 + TMO, 1'b0);
    exp_push(8'h61, 1'b0, 3 + TMO, 1'b1);
    exp_push(8'h71, 1'b1, 13, 1'b0);
    fork
      begin push_a(8'h60); push_a(8'h61); end
      begin push_b(8'h70); push_b(8'h71); end
    join
    mdl_en = 1'b1;
    wait_drain(300);

    // Reset during WAIT_DONE with two bytes queued
    do_reset();
    mdl_push(3, 0);
    exp_push(8'h80, 1'b0, 0, 1'b0);
    fork
      begin push_a(8'h80); push_a(8'h81); end
      begin push_b(8'h90); end
    join
    mdl_en = 1'b1;
    n = 0;
    while (!tx_start && n < 20) begin
      @(negedge clk);
      n++;
    end
    repeat (6) @(negedge clk);
    chk("mid_busy_before_rst", 32'(busy), 32'(1'b1));
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_tx_start", 32'(tx_start), 32'(1'b0));
    chk("mid_rst_busy", 32'(busy), 32'(1'b0));
    chk("mid_rst_a_ready", 32'(a_ready), 32'(1'b0));
    chk("mid_rst_b_ready", 32'(b_ready), 32'(1'b0));
    chk("mid_rst_tx_word", 32'(tx_word), 32'(8'h00));
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("mid_after_busy", 32'(busy), 32'(1'b0));
    chk("mid_after_a_ready", 32'(a_ready), 32'(1'b1));

    // Push to A on the same edge its last entry is popped
    do_reset();
    exp_push(8'hA0, 1'b0, 13, 1'b0);
    exp_push(8'hA1, 1'b0, 13, 1'b0);
    push_a(8'hA0);
    a_data  = 8'hA1;
    a_valid = 1'b1;
    mdl_en  = 1'b1;
    @(negedge clk);
    a_valid = 1'b0;
    chk("simul_started", 32'(tx_start), 32'(1'b1));
    wait_drain(200);

    chk("scoreboard_empty", 32'(exp_q.size()), 32'(0));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one UART transmit engine between two byte sources, A (the echo path) and B (the local message/status generator).
- Each source has a small FIFO. The block round-robins between non-empty FIFOs and sequences the transmitter with a level start / ready handshake.
- A watchdog releases the transmitter if it never starts or never finishes a byte.
- Sits between the receive/echo logic and the transmit module, replacing ad-hoc connection_status driving.

Parameters:
- FIFO_DEPTH, 4: entries per source FIFO. Must be a power of 2, ≥2.
- TIMEOUT, 1023: cycles allowed in each wait state before abort. Range 2..1023; the counter is 10 bits.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-low reset.
- a_data  in  8  source A byte.
- a_valid  in  1  source A byte valid.
- a_ready  out  1  source A FIFO can accept.
- b_data  in  8  source B byte.
- b_valid  in  1  source B byte valid.
- b_ready  out  1  source B FIFO can accept.
- tx_word  out  8  byte presented to the transmitter.
- tx_start  out  1  level request to the transmitter (connection_status semantics).
- tx_ready  in  1  transmitter idle/finished.
- grant  out  1  source of the current/last byte: 0=A, 1=B.
- busy  out  1  FSM not in IDLE.
- timeout_err  out  1  one-cycle pulse on watchdog abort.

Behaviour:
- Reset:
  - Sampled on posedge clk only; rst=0 → all state cleared.
  - FIFOs are emptied and the FSM goes to IDLE. The wait counter is 0. rr_pri=0 (A has priority).
  - Outputs during and after reset: tx_word=0, tx_start=0, grant=0, busy=0, timeout_err=0, a_ready=0, b_ready=0.
  - a_ready and b_ready go high on the first cycle after rst returns to 1.
  - Reset mid-transfer drops the in-flight byte and all queued bytes; tx_start falls on the same edge.
- FIFOs:
  - x_ready = !full_x.
  - Push on posedge when x_valid && x_ready.
  - Pop only by the FSM in IDLE.
  - No bypass: a byte pushed at edge k is eligible at edge k+1. tx_start is high after edge k+1 (1-cycle latency when idle).
  - Push and pop on the same edge are allowed when not full; the count is unchanged.
  - Pointers wrap modulo FIFO_DEPTH. Full and empty come from a count of width clog2(FIFO_DEPTH)+1.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if tx_ready=1 and any FIFO is non-empty, select a source:
    - Only one FIFO non-empty → that source.
    - Both non-empty → source rr_pri.
    - On the selected source: pop it, tx_word←head, grant←source, tx_start←1, cnt←0, then go to WAIT_BUSY.
    - If tx_ready=0, stay in IDLE; no pop.
  - WAIT_BUSY: tx_start stays 1 and tx_word is held. cnt increments each cycle.
    - tx_ready=0 → WAIT_DONE, cnt←0.
    - Else if cnt==TIMEOUT-1 → abort.
  - WAIT_DONE: tx_start stays 1 and tx_word is held. cnt increments each cycle.
    - tx_ready=1 → tx_start←0, rr_pri←!grant, go to IDLE.
    - Else if cnt==TIMEOUT-1 → abort.
  - Abort:
    - tx_start←0, timeout_err=1 for exactly one cycle, rr_pri←!grant, go to IDLE.
    - The byte is dropped, not retried.
- Throughput: after completion, IDLE spends ≥1 cycle with tx_start=0 before the next byte. This guarantees a start falling edge between bytes.
- tx_word and grant keep their last value in IDLE.
- Simultaneous events:
  - A FIFO may be pushed in the same cycle it is popped.
  - tx_ready and timeout in the same cycle → the handshake wins, no error.

Test Plan:
- Single byte: after reset, a_data=0x41, a_valid=1 for 1 cycle; transmitter model drops ready 3 cycles after start and raises it 10 cycles later → tx_start high for 13 cycles, tx_word=0x41, grant=0, busy matches, no timeout_err.
- Round-robin: preload A with 0x10,0x11 and B with 0x20,0x21 while tx_ready=0, then release → transmitted order 0x10,0x20,0x11,0x21; grant toggles 0,1,0,1.
- Full / backpressure: FIFO_DEPTH=4, tx_ready held 0, A pushes 6 bytes → a_ready falls after the 4th accept; bytes 5 and 6 are held by the source; later the order is 0..5 with none lost.
- Timeout: TIMEOUT=8, tx_ready stays 1 after start → tx_start drops and timeout_err pulses on cycle 8; FSM returns to IDLE and the next queued byte (other source first) starts.
- Reset mid-op: assert rst=0 during WAIT_DONE with 2 bytes queued → next edge tx_start=0, busy=0, a_ready=b_ready=0; after release, no byte is transmitted.
- Simultaneous: push to A on the same edge the FSM pops A's last entry → the new byte is sent next with no duplication or loss.
